// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and encodings for the memory arbiter
package cpu_pkg;
  localparam int AW = 4;
  localparam int DW = 8;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two requester ports plus the memory side of the arbiter
interface mem_arbiter_if #(
  parameter int AW = cpu_pkg::AW,
  parameter int DW = cpu_pkg::DW
) ();
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_w;
  logic          mem_we;
  logic [DW-1:0] mem_data_r;
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_data_r,
    input  a_ack, a_rdata, b_ack, b_rdata, mem_address, mem_data_w, mem_we
  );
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_data_r,
    output a_ack, a_rdata, b_ack, b_rdata, mem_address, mem_data_w, mem_we
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker
module rr_arb2
  import cpu_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_owner
);
  always_comb begin
    grant_valid = req_a | req_b;
    grant_owner = (req_a & req_b) ? ~last_grant : (req_b ? OWN_B : OWN_A);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between two req/ack ports, one access at a time
module mem_arbiter
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus,
  output logic [1:0]   dbg_state,
  output logic         dbg_owner
);
  state_t state, state_n;
  logic   owner;
  logic   grant_valid, grant_owner;
  rr_arb2 u_arb (
    .req_a      (bus.a_req),
    .req_b      (bus.b_req),
    .last_grant (owner),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );
  always_comb begin
    state_n = state == ST_IDLE   ? (grant_valid ? ST_ACCESS : ST_IDLE) :
              state == ST_ACCESS ? ST_DONE : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else state <= state_n;
  end
  // mem_we still holds the granted direction during ACCESS, so it selects the read capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner           <= OWN_B;
      bus.mem_address <= '0;
      bus.mem_data_w  <= '0;
      bus.mem_we      <= 1'b0;
      bus.a_ack       <= 1'b0;
      bus.b_ack       <= 1'b0;
      bus.a_rdata     <= '0;
      bus.b_rdata     <= '0;
    end else begin
      if (state == ST_IDLE && grant_valid) begin
        owner           <= grant_owner;
        bus.mem_address <= grant_owner ? bus.b_addr : bus.a_addr;
        bus.mem_data_w  <= grant_owner ? bus.b_wdata : bus.a_wdata;
        bus.mem_we      <= grant_owner ? bus.b_we : bus.a_we;
      end
      if (state == ST_ACCESS) begin
        bus.mem_we <= 1'b0;
        bus.a_ack  <= owner == OWN_A;
        bus.b_ack  <= owner == OWN_B;
        if (!bus.mem_we && owner == OWN_A) bus.a_rdata <= bus.mem_data_r;
        if (!bus.mem_we && owner == OWN_B) bus.b_rdata <= bus.mem_data_r;
      end
      if (state == ST_DONE) begin
        bus.a_ack <= 1'b0;
        bus.b_ack <= 1'b0;
      end
    end
  end
  assign dbg_state = state;
  assign dbg_owner = owner;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, handshake timing and reset
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] dbg_state;
  logic       dbg_owner;
  int         total = 0;
  int         bad = 0;
  logic [7:0] mem [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                           8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};
  mem_arbiter_if #(.AW(4), .DW(8)) ifc ();
  mem_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (ifc.slave),
    .dbg_state(dbg_state),
    .dbg_owner(dbg_owner)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ifc.mem_we) mem[ifc.mem_address] <= ifc.mem_data_w;
  assign ifc.mem_data_r = mem[ifc.mem_address];
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input logic port, input logic r, input logic we, input logic [3:0] addr, input logic [7:0] wd);
    if (!port) begin
      ifc.a_req = r; ifc.a_we = we; ifc.a_addr = addr; ifc.a_wdata = wd;
    end else begin
      ifc.b_req = r; ifc.b_we = we; ifc.b_addr = addr; ifc.b_wdata = wd;
    end
  endtask
  task automatic acc(input logic port, input logic we, input logic [3:0] addr, input logic [7:0] wd);
    set_req(port, 1'b1, we, addr, wd);
    cyc();
    chk("acc_state1", 8'(dbg_state), 8'd1);
    chk("acc_we", 8'(ifc.mem_we), 8'(we));
    chk("acc_addr", 8'(ifc.mem_address), 8'(addr));
    chk("acc_owner", 8'(dbg_owner), 8'(port));
    if (we) chk("acc_wdata", ifc.mem_data_w, wd);
    set_req(port, 1'b1, ~we, ~addr, ~wd);
    cyc();
    chk("acc_state2", 8'(dbg_state), 8'd2);
    chk("acc_we_off", 8'(ifc.mem_we), 8'd0);
    chk("acc_a_ack", 8'(ifc.a_ack), 8'(!port));
    chk("acc_b_ack", 8'(ifc.b_ack), 8'(port));
    set_req(port, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc();
    chk("acc_state0", 8'(dbg_state), 8'd0);
    chk("acc_ack_low", 8'(ifc.a_ack | ifc.b_ack), 8'd0);
  endtask
  initial begin
    reset_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    set_req(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc();
    cyc();
    chk("rst_state", 8'(dbg_state), 8'd0);
    chk("rst_owner", 8'(dbg_owner), 8'd1);
    chk("rst_we", 8'(ifc.mem_we), 8'd0);
    chk("rst_addr", 8'(ifc.mem_address), 8'd0);
    chk("rst_wdata", ifc.mem_data_w, 8'd0);
    chk("rst_acks", 8'(ifc.a_ack | ifc.b_ack), 8'd0);
    chk("rst_a_rdata", ifc.a_rdata, 8'd0);
    chk("rst_b_rdata", ifc.b_rdata, 8'd0);
    reset_n = 1'b1;
    cyc();
    chk("idle_hold", 8'(dbg_state), 8'd0);
    acc(1'b0, 1'b1, 4'd3, 8'h5A);
    chk("mem3_written", mem[3], 8'h5A);
    chk("mem12_untouched", mem[12], 8'h1C);
    chk("a_rdata_after_write", ifc.a_rdata, 8'd0);
    acc(1'b1, 1'b0, 4'd3, 8'h00);
    chk("b_rdata_read", ifc.b_rdata, 8'h5A);
    chk("a_rdata_kept", ifc.a_rdata, 8'd0);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 4'd1, 8'd0);
    set_req(1'b1, 1'b1, 1'b0, 4'd2, 8'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("dual_a_ack%0d", k), 8'(ifc.a_ack), 8'(k == 2 || k == 8));
      chk($sformatf("dual_b_ack%0d", k), 8'(ifc.b_ack), 8'(k == 5 || k == 11));
      chk($sformatf("dual_excl%0d", k), 8'(ifc.a_ack & ifc.b_ack), 8'd0);
      if (k % 3 == 1) chk($sformatf("dual_owner%0d", k), 8'(dbg_owner), 8'((k / 3) % 2));
      if (k == 2) chk("dual_a_rdata", ifc.a_rdata, 8'h11);
      if (k == 5) chk("dual_b_rdata", ifc.b_rdata, 8'h12);
      if (k == 11) begin
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        set_req(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      end
    end
    chk("dual_idle", 8'(dbg_state), 8'd0);
    set_req(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk($sformatf("b2b_a_ack%0d", k), 8'(ifc.a_ack), 8'(k % 3 == 2));
      chk($sformatf("b2b_b_ack%0d", k), 8'(ifc.b_ack), 8'd0);
      if (k % 3 == 2) begin
        chk($sformatf("b2b_rdata%0d", k), ifc.a_rdata, 8'(8'h10 + k / 3));
        set_req(1'b0, k < 8, 1'b0, 4'(k / 3 + 1), 8'd0);
      end
    end
    chk("b2b_idle", 8'(dbg_state), 8'd0);
    set_req(1'b0, 1'b1, 1'b0, 4'd5, 8'd0);
    cyc();
    chk("rstmid_access", 8'(dbg_state), 8'd1);
    reset_n = 1'b0;
    cyc();
    chk("rstmid_state", 8'(dbg_state), 8'd0);
    chk("rstmid_ack", 8'(ifc.a_ack), 8'd0);
    chk("rstmid_we", 8'(ifc.mem_we), 8'd0);
    chk("rstmid_owner", 8'(dbg_owner), 8'd1);
    chk("rstmid_rdata", ifc.a_rdata, 8'd0);
    reset_n = 1'b1;
    cyc();
    chk("retry_grant", 8'(dbg_state), 8'd1);
    chk("retry_owner", 8'(dbg_owner), 8'd0);
    cyc();
    chk("retry_ack", 8'(ifc.a_ack), 8'd1);
    chk("retry_rdata", ifc.a_rdata, 8'h15);
    set_req(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc();
    chk("retry_idle", 8'(dbg_state), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16x8 program/data memory between two requesters over a req/ack handshake.
- Port A is the CPU-side wrapper. Port B is the program loader / debug host.
- Sits between the requesters and the memory array and owns the memory write enable.
- Fixed 2-way round-robin arbitration; one access in flight at a time.

Parameters:
AW, 4, memory address width (16 words)
DW, 8, memory data width

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
a_req  in  1  port A access request, held until a_ack
a_we  in  1  port A: 1 = write, 0 = read; stable while a_req
a_addr  in  AW  port A address; stable while a_req
a_wdata  in  DW  port A write data; stable while a_req
a_ack  out  1  port A completion pulse, one cycle
a_rdata  out  DW  port A read data, valid from a_ack onward
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same directions/widths as port A, for port B
mem_address  out  AW  memory address, registered
mem_data_w  out  DW  memory write data, registered
mem_we  out  1  memory write enable, registered
mem_data_r  in  DW  memory read data, combinational from mem_address
dbg_state  out  2  FSM state: 0 IDLE, 1 ACCESS, 2 DONE
dbg_owner  out  1  current/last granted port: 0 = A, 1 = B

Behaviour:
- Reset (reset_n low at rising edge), all registered outputs:
  - state IDLE; mem_address 0, mem_data_w 0, mem_we 0.
  - a_ack/b_ack 0; a_rdata/b_rdata 0.
  - last_grant = B, so A wins the first contention; dbg_owner reads 1 after reset.
- IDLE:
  - If no req, stay.
  - If exactly one req, grant it.
  - If both, grant the port != last_grant.
  - On grant: latch owner into last_grant; mem_address <= x_addr; mem_data_w <= x_wdata; mem_we <= x_we; go ACCESS.
- ACCESS:
  - mem_we <= 0, so the write strobe is exactly one cycle.
  - If the owner's access is a read: owner rdata <= mem_data_r.
  - Owner ack <= 1; go DONE.
- DONE:
  - Ack is high this cycle; requester drops or re-presents req at the next edge.
  - ack <= 0; go IDLE.
  - req is not sampled in DONE, so a held req is never double-granted.
- Latency and throughput:
  - req sampled in IDLE at edge N; mem_we/address valid during cycle N+1; ack high during cycle N+2.
  - Minimum 3 cycles per access.
  - Continuous dual requests alternate A, B, A, B.
  - A continuously held single req yields one access every 3 cycles.
- Write data: memory captures the write at the edge ending the ACCESS cycle.
- rdata:
  - Updated only on that port's reads; writes leave it unchanged.
  - Holds its value until that port's next read.
- Request/data stability:
  - Request fields are captured at grant; later changes to addr/wdata/we do not affect the in-flight access.
  - req dropped after grant: the access still completes and ack still pulses (requester protocol violation, tolerated).
- The non-owner's ack is never asserted. a_ack and b_ack are never high together.
- Reset mid-operation:
  - Reset during ACCESS: the write strobed in that cycle may land in memory, but no ack is issued.
  - All state returns to reset values at that edge.
- No combinational path from any req to any ack or memory output.

Decomposition:
- Shared package cpu_pkg holds:
  - AW/DW defaults;
  - arbiter state encodings (ST_IDLE=0, ST_ACCESS=1, ST_DONE=2);
  - owner encodings (OWN_A=0, OWN_B=1).
- One sub-module is natural: rr_arb2.
  - Combinational 2-way round-robin picker.
  - Inputs: req_a, req_b, last_grant. Outputs: grant_valid, grant_owner.
  - Instantiated in IDLE decode.

Test Plan:
1. Hold reset_n low 2 cycles, then release -> all outputs 0, dbg_state 0, dbg_owner 1.
2. A writes 0x5A to addr 3 -> mem_we high for exactly one cycle with mem_address 3, mem_data_w 0x5A; a_ack pulses 2 cycles after grant edge; b_ack stays 0.
3. B reads addr 3 after step 2 -> b_rdata 0x5A at b_ack; a_rdata unchanged.
4. a_req and b_req rise in the same cycle after reset, both held with different addrs -> grant order A, B, A, B; acks spaced 3 cycles; no cycle with both acks high.
5. A holds req over 3 back-to-back reads of addrs 0, 1, 2 (addr changed in the DONE cycle) -> three acks at 3-cycle spacing, rdata equals memory contents in order.
6. reset_n low during ACCESS of an A read -> no a_ack, dbg_state 0 next cycle, mem_we 0; a fresh A req afterwards completes normally.
